tetris_driver: RTL and testbench

- Synthesizable initiator for the TETRIS game interface. Drives the `in_valid`/`tetrominoes`/`position` inputs and consumes `score_valid`/`tetris_valid`/`fail`/`score`/`tetris`.
- Produces one game of pseudo-random legal drops from an internal LFSR, one piece per handshake.
- Captures the final board and score, and flags protocol or timeout violations. Used as an on-chip self-test source and as a bench stimulus generator.

---
 rtl/tetris_driver.sv | 162 ++++++++++++++++
 tb/tb_tetris_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_driver.sv
// Self-test initiator for the TETRIS engine: issues NUM_PIECES LFSR-chosen legal drops,
// one per score handshake, then captures the final board/score and flags engine misbehaviour.
module tetris_driver #(
    parameter int         NUM_PIECES = 16,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         TIMEOUT    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in_valid,
    output logic [2:0]  tetrominoes,
    output logic [2:0]  position,
    input  logic        score_valid,
    input  logic        tetris_valid,
    input  logic        fail,
    input  logic [3:0]  score,
    input  logic [71:0] tetris,
    output logic        busy,
    output logic        done,
    output logic        game_fail,
    output logic        proto_err,
    output logic        timeout_err,
    output logic [4:0]  pieces_sent,
    output logic [3:0]  final_score,
    output logic [71:0] board
);

    localparam int               TMR_W      = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [4:0]       LAST_PIECE = 5'(NUM_PIECES);
    localparam logic [7:0]       SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [4:0]         pieces_q, pieces_d;
    logic [3:0]         score_q, score_d;
    logic [71:0]        board_q, board_d;
    logic               gfail_q, gfail_d;
    logic               perr_q, perr_d;
    logic               terr_q, terr_d;

    // Rightmost legal leftmost column, i.e. 6 - piece width.
    function automatic logic [2:0] max_pos(input logic [2:0] kind);
        case (kind)
            3'd1:       return 3'd5;
            3'd2:       return 3'd2;
            3'd4, 3'd7: return 3'd3;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= 8'h01;
            timer_q  <= '0;
            pieces_q <= '0;
            score_q  <= '0;
            board_q  <= '0;
            gfail_q  <= 1'b0;
            perr_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            timer_q  <= timer_d;
            pieces_q <= pieces_d;
            score_q  <= score_d;
            board_q  <= board_d;
            gfail_q  <= gfail_d;
            perr_q   <= perr_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        timer_d  = timer_q;
        pieces_d = pieces_q;
        score_d  = score_q;
        board_d  = board_q;
        gfail_d  = gfail_q;
        perr_d   = perr_q;
        terr_d   = terr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_d   = SEED_EFF;
                    pieces_d = '0;
                    score_d  = '0;
                    board_d  = '0;
                    gfail_d  = 1'b0;
                    perr_d   = 1'b0;
                    terr_d   = 1'b0;
                    state_d  = ISSUE;
                end
                if (score_valid) perr_d = 1'b1;
            end
            ISSUE: begin
                pieces_d = pieces_q + 5'd1;
                lfsr_d   = lfsr_step(lfsr_q);
                timer_d  = '0;
                state_d  = WAIT;
                if (score_valid) perr_d = 1'b1;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (tetris_valid && !score_valid) begin
                    perr_d  = 1'b1;
                    state_d = DONE;
                end else if (score_valid) begin
                    score_d = score;
                    if (tetris_valid) begin
                        board_d = tetris;
                        gfail_d = fail;
                        state_d = DONE;
                    end else if (pieces_q == LAST_PIECE) begin
                        // The engine must close the game on the last piece.
                        perr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_valid    = 1'b0;
        tetrominoes = 3'd0;
        position    = 3'd0;
        if (state_q == ISSUE) begin
            in_valid    = 1'b1;
            tetrominoes = lfsr_q[2:0];
            position    = (lfsr_q[5:3] <= max_pos(lfsr_q[2:0])) ? lfsr_q[5:3] : max_pos(lfsr_q[2:0]);
        end
    end

    assign busy        = (state_q == ISSUE) || (state_q == WAIT);
    assign done        = (state_q == DONE);
    assign game_fail   = gfail_q;
    assign proto_err   = perr_q;
    assign timeout_err = terr_q;
    assign pieces_sent = pieces_q;
    assign final_score = score_q;
    assign board       = board_q;

endmodule

// File: tb/tb_tetris_driver.sv
// Bench for tetris_driver: a reactive engine model drives responses while a cycle reference,
// built from the game rules and a precomputed piece sequence, is compared every cycle.
module tb_tetris_driver;

    localparam int         NP = 16;
    localparam logic [7:0] SD = 8'hA5;
    localparam int         TO = 100;

    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst, start, score_valid, tetris_valid, fail;
    logic [3:0]  score;
    logic [71:0] tetris;
    logic        in_valid, busy, done, game_fail, proto_err, timeout_err;
    logic [2:0]  tetrominoes, position;
    logic [4:0]  pieces_sent;
    logic [3:0]  final_score;
    logic [71:0] board;

    tetris_driver #(.NUM_PIECES(NP), .SEED(SD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .tetrominoes(tetrominoes), .position(position),
        .score_valid(score_valid), .tetris_valid(tetris_valid), .fail(fail),
        .score(score), .tetris(tetris),
        .busy(busy), .done(done), .game_fail(game_fail), .proto_err(proto_err),
        .timeout_err(timeout_err), .pieces_sent(pieces_sent),
        .final_score(final_score), .board(board)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Piece sequence derived directly from the LFSR recurrence and the width table.
    logic [2:0] seq_t [32];
    logic [2:0] seq_p [32];

    function automatic void build_seq();
        int         width [8] = '{2, 1, 4, 2, 3, 2, 2, 3};
        logic [7:0] l;
        int         raw, maxp;
        l = (SD == 8'h00) ? 8'h01 : SD;
        for (int k = 0; k < 32; k++) begin
            raw  = int'(l[5:3]);
            maxp = 6 - width[l[2:0]];
            seq_t[k] = l[2:0];
            seq_p[k] = 3'((raw <= maxp) ? raw : maxp);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endfunction

    // Reference model of the observable game state.
    int          m_mode = M_IDLE;
    int          m_cnt = 0;
    int          m_wait = 0;
    logic [3:0]  m_score = '0;
    logic [71:0] m_board = '0;
    logic        m_gf = 1'b0, m_pe = 1'b0, m_te = 1'b0;
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= M_IDLE; m_cnt <= 0; m_wait <= 0; m_score <= '0; m_board <= '0;
            m_gf <= 1'b0; m_pe <= 1'b0; m_te <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_cnt <= 0; m_score <= '0; m_board <= '0;
                        m_gf <= 1'b0; m_pe <= 1'b0; m_te <= 1'b0; m_mode <= M_ISSUE;
                    end
                    if (score_valid) m_pe <= 1'b1;
                end
                M_ISSUE: begin
                    m_cnt <= m_cnt + 1; m_wait <= 0; m_mode <= M_WAIT;
                    if (score_valid) m_pe <= 1'b1;
                end
                default: begin
                    m_wait <= m_wait + 1;
                    if (tetris_valid && !score_valid) begin
                        m_pe <= 1'b1; m_mode <= M_DONE;
                    end else if (score_valid) begin
                        m_score <= score;
                        if (tetris_valid) begin
                            m_board <= tetris; m_gf <= fail; m_mode <= M_DONE;
                        end else if (m_cnt == NP) begin
                            m_pe <= 1'b1; m_mode <= M_DONE;
                        end else m_mode <= M_ISSUE;
                    end else if (m_wait == TO - 1) begin
                        m_te <= 1'b1; m_mode <= M_DONE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic iss;
            iss = (m_mode == M_ISSUE);
            check("cycle",
                  {in_valid, tetrominoes, position, busy, done, game_fail, proto_err,
                   timeout_err, pieces_sent, final_score},
                  {iss, iss ? seq_t[m_cnt] : 3'd0, iss ? seq_p[m_cnt] : 3'd0,
                   (m_mode == M_ISSUE || m_mode == M_WAIT), (m_mode == M_DONE),
                   m_gf, m_pe, m_te, 5'(m_cnt), m_score});
            check("board", board, m_board);
        end
    end

    // Reactive engine stimulus.
    int          cyc = 0, seen = 0, pend = 0;
    int          dmin = 3, dmax = 3;
    int          end_piece = NP, tv_only = 0, stop_after = 0;
    bit          end_fail = 1'b0, fix_score = 1'b0, stray_sv = 1'b0;
    logic [3:0]  fixed_score = 4'd7;
    logic [71:0] last_board = '0;
    logic [2:0]  obs_t [32];
    logic [2:0]  obs_p [32];
    int          issue_cyc [32];

    task automatic respond();
        if (tv_only == seen) begin
            tetris_valid = 1'b1;
            fail = 1'($urandom_range(0, 1));
            tetris = 72'({$urandom(), $urandom(), $urandom()});
        end else begin
            score_valid = 1'b1;
            if (fix_score && seen == end_piece) score = fixed_score;
            if (seen == end_piece) begin
                tetris_valid = 1'b1;
                fail = end_fail;
                tetris = 72'({$urandom(), $urandom(), $urandom()});
                last_board = tetris;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        score_valid = 1'b0; tetris_valid = 1'b0; fail = 1'b0; start = 1'b0;
        score = 4'($urandom_range(0, 15));
        if (stray_sv) begin score_valid = 1'b1; stray_sv = 1'b0; end
        if (pend > 0) begin
            pend--;
            if (pend == 0) respond();
        end
        if (in_valid === 1'b1) begin
            if (seen < 32) begin
                obs_t[seen] = tetrominoes; obs_p[seen] = position; issue_cyc[seen] = cyc;
            end
            seen++;
            if (stop_after == 0 || seen < stop_after) pend = $urandom_range(dmin, dmax);
        end
    endtask

    task automatic start_game();
        seen = 0; pend = 0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin tick(); k++; end
        check("wait_done", done, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; pend = 0; seen = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k, t0;
        build_seq();
        rst = 1'b1; start = 1'b0; score_valid = 1'b0; tetris_valid = 1'b0; fail = 1'b0;
        score = '0; tetris = '0;
        tick(); tick();
        chk_on = 1'b1;
        rst = 1'b0;
        tick();
        check("reset_outputs", {in_valid, tetrominoes, position, busy, done, game_fail,
              proto_err, timeout_err, pieces_sent, final_score, board}, '0);
        check("model_seq0", {seq_t[0], seq_p[0]}, {3'd5, 3'd4});
        check("model_seq1", {seq_t[1], seq_p[1]}, {3'd2, 3'd1});

        // Full game, engine answers 3 cycles after each piece, closes on piece 16 with score 7.
        dmin = 3; dmax = 3; end_piece = NP; end_fail = 1'b0; fix_score = 1'b1;
        start_game();
        wait_done(600);
        check("first_piece", {obs_t[0], obs_p[0]}, {3'd5, 3'd4});
        check("second_piece", {obs_t[1], obs_p[1]}, {3'd2, 3'd1});
        check("piece_spacing", issue_cyc[1] - issue_cyc[0], 4);
        check("full_pieces", pieces_sent, 5'd16);
        check("full_score", final_score, 4'd7);
        check("full_board", board, last_board);
        check("full_flags", {game_fail, proto_err, timeout_err}, 3'b000);
        fix_score = 1'b0;

        // Early end with overflow on piece 5.
        end_piece = 5; end_fail = 1'b1;
        start_game();
        wait_done(600);
        check("early_fail", {game_fail, proto_err, pieces_sent}, {1'b1, 1'b0, 5'd5});

        // Engine goes silent on piece 3.
        end_piece = NP; end_fail = 1'b0; stop_after = 3;
        start_game();
        k = 0;
        while (timeout_err !== 1'b1 && k < 400) begin tick(); k++; end
        t0 = cyc - issue_cyc[2];
        check("timeout_latency", t0, TO + 1);
        check("timeout_state", {done, timeout_err, pieces_sent}, {1'b1, 1'b1, 5'd3});
        stop_after = 0;

        // Last piece answered without game end, then a stray response while idle.
        end_piece = 0;
        start_game();
        wait_done(600);
        check("unclosed_game", {done, proto_err, pieces_sent}, {1'b1, 1'b1, 5'd16});
        pulse_reset();
        stray_sv = 1'b1;
        tick(); tick();
        check("stray_idle", {proto_err, busy, done}, {1'b1, 1'b0, 1'b0});

        // Start while busy is ignored; reset during WAIT of piece 8 clears everything.
        end_piece = NP;
        start_game();
        k = 0;
        while (!(seen == 8 && in_valid === 1'b0) && k < 600) begin tick(); k++; end
        start = 1'b1;
        tick();
        check("start_ignored", {busy, pieces_sent}, {1'b1, 5'd8});
        pulse_reset();
        check("reset_midgame", {in_valid, tetrominoes, position, busy, done, game_fail,
              proto_err, timeout_err, pieces_sent, final_score, board}, '0);

        // Randomised games.
        for (int g = 0; g < 24; g++) begin
            int mode;
            dmin = $urandom_range(1, 3);
            dmax = dmin + $urandom_range(0, 4);
            end_piece = NP; end_fail = 1'($urandom_range(0, 1)); tv_only = 0; stop_after = 0;
            mode = $urandom_range(0, 9);
            if (mode == 5 || mode == 6) begin end_piece = $urandom_range(1, NP); end_fail = 1'b1; end
            else if (mode == 7) end_piece = 0;
            else if (mode == 8) tv_only = $urandom_range(1, NP);
            else if (mode == 9) stop_after = $urandom_range(1, NP);
            start_game();
            wait_done(2 * TO + NP * 12);
            if ($urandom_range(0, 3) == 0) begin stray_sv = 1'b1; tick(); end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
